mem_bus_arbiter: RTL

Shares the single external memory bus between the core's instruction-fetch port and its load/store data port. Data requests come from the decoder's `bus_read`/`bus_write` controls. The block has a three-state FSM and alternating fairness on contention. It registers the memory-side request, returns a one-cycle ack (with error on timeout) to the winning port, and lets the core stall until that ack arrives. It sits between the core datapath and the memory/peripheral bus.

---
 rtl/mem_bus_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the fetch port and the load/store port. The FSM has three
// states, contention alternates between the ports, and a bus that never answers times out.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    output logic                if_err,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                d_err,
    output logic                m_valid,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ready
);

    localparam int unsigned StrbW = DATA_W / 8;
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
    localparam logic GrantIf = 1'b0;
    localparam logic GrantD  = 1'b1;

    typedef enum logic [1:0] {StIdle, StIfBusy, StDBusy} state_e;

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               m_valid_q, m_valid_d;
    logic               m_we_q, m_we_d;
    logic [ADDR_W-1:0]  m_addr_q, m_addr_d;
    logic [DATA_W-1:0]  m_wdata_q, m_wdata_d;
    logic [StrbW-1:0]   m_wstrb_q, m_wstrb_d;
    logic               if_ack_q, if_ack_d;
    logic               if_err_q, if_err_d;
    logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
    logic               d_ack_q, d_ack_d;
    logic               d_err_q, d_err_d;
    logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;
    logic               if_req_m;
    logic               d_req_m;
    logic               grant_d;

    // A port is still holding its request during its own ack cycle; keep it from being re-served.
    assign if_req_m = if_req & ~if_ack_q;
    assign d_req_m  = (d_read | d_write) & ~d_ack_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        m_valid_d    = m_valid_q;
        m_we_d       = m_we_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        m_wstrb_d    = m_wstrb_q;
        if_ack_d     = 1'b0;
        if_err_d     = 1'b0;
        if_rdata_d   = '0;
        d_ack_d      = 1'b0;
        d_err_d      = 1'b0;
        d_rdata_d    = '0;
        grant_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                grant_d = d_req_m & (~if_req_m | (last_grant_q == GrantIf));
                if (grant_d) begin
                    m_valid_d    = 1'b1;
                    m_we_d       = d_write;
                    m_addr_d     = d_addr;
                    m_wdata_d    = d_write ? d_wdata : '0;
                    m_wstrb_d    = d_write ? d_wstrb : '0;
                    last_grant_d = GrantD;
                    cnt_d        = '0;
                    state_d      = StDBusy;
                end else if (if_req_m) begin
                    m_valid_d    = 1'b1;
                    m_we_d       = 1'b0;
                    m_addr_d     = if_addr;
                    m_wdata_d    = '0;
                    m_wstrb_d    = '0;
                    last_grant_d = GrantIf;
                    cnt_d        = '0;
                    state_d      = StIfBusy;
                end
            end
            StIfBusy, StDBusy: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = StIdle;
                    if (state_q == StIfBusy) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = m_rdata;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = m_we_q ? '0 : m_rdata;
                    end
                end else if (cnt_q == TimeoutLast) begin
                    m_valid_d = 1'b0;
                    state_d   = StIdle;
                    if (state_q == StIfBusy) begin
                        if_ack_d = 1'b1;
                        if_err_d = 1'b1;
                    end else begin
                        d_ack_d = 1'b1;
                        d_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= GrantIf;
            cnt_q        <= '0;
            m_valid_q    <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            m_wstrb_q    <= '0;
            if_ack_q     <= 1'b0;
            if_err_q     <= 1'b0;
            if_rdata_q   <= '0;
            d_ack_q      <= 1'b0;
            d_err_q      <= 1'b0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            m_valid_q    <= m_valid_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            m_wstrb_q    <= m_wstrb_d;
            if_ack_q     <= if_ack_d;
            if_err_q     <= if_err_d;
            if_rdata_q   <= if_rdata_d;
            d_ack_q      <= d_ack_d;
            d_err_q      <= d_err_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign m_wstrb  = m_wstrb_q;
    assign if_ack   = if_ack_q;
    assign if_err   = if_err_q;
    assign if_rdata = if_rdata_q;
    assign d_ack    = d_ack_q;
    assign d_err    = d_err_q;
    assign d_rdata  = d_rdata_q;

endmodule
